// File: rtl/accel_spi_sampler_pkg.sv
// Shared types and frame constants for the SPI accelerometer sampler.
package accel_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int SPI_RD_BIT = 7;
    localparam int SPI_MB_BIT = 6;
    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } spi_state_t;

    // Read command with auto-increment so lo and hi bytes arrive in one frame.
    function automatic logic [CMD_BITS-1:0] spi_read_cmd(input logic [5:0] addr);
        logic [CMD_BITS-1:0] cmd;
        cmd             = {2'b00, addr};
        cmd[SPI_RD_BIT] = 1'b1;
        cmd[SPI_MB_BIT] = 1'b1;
        return cmd;
    endfunction

endpackage

// File: rtl/accel_spi_sampler_if.sv
// SPI bus between the sampler (master) and the accelerometer (slave).
interface accel_spi_sampler_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/accel_spi_sampler_edge_gen.sv
// SCLK half-period timing: strobes on the last cycle of each low/high half.
module spi_edge_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic fall_en,
    output logic rise_en
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] half_cnt;
    logic             high_half;

    assign rise_en = run && (half_cnt == '0) && !high_half;
    assign fall_en = run && (half_cnt == '0) && high_half;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            half_cnt  <= DIV_W'(CLK_DIV - 1);
            high_half <= 1'b0;
        end else if (half_cnt == '0) begin
            half_cnt  <= DIV_W'(CLK_DIV - 1);
            high_half <= !high_half;
        end else begin
            half_cnt <= half_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/accel_spi_sampler.sv
// Periodic SPI mode-3 read of one 16-bit accelerometer axis, presented as a
// signed sample with a one-cycle valid strobe.
//
//   state    | meaning
//   IDLE     | cs_n high, waiting for a sample tick
//   CS_SETUP | cs_n low, CLK_DIV cycles before the first SCLK fall
//   SHIFT    | 24 SCLK periods: 8 command bits out, 16 data bits in
//   CS_HOLD  | sclk high, CLK_DIV cycles before cs_n releases
module accel_spi_sampler
    import accel_pkg::*;
#(
    parameter int         STATE_BITS    = 16,
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [5:0] REG_ADDR      = 6'h36
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    accel_spi_sampler_if.master          spi,
    output logic signed [STATE_BITS-1:0] z_out,
    output logic                         z_valid,
    output logic                         busy,
    output logic                         sample_missed
);
    localparam int                  TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int                  DIV_W = $clog2(CLK_DIV);
    localparam logic [CMD_BITS-1:0] CMD   = spi_read_cmd(REG_ADDR);

    logic [TMR_W-1:0]    timer;
    logic                tick;
    spi_state_t          state;
    logic [DIV_W-1:0]    wait_cnt;
    logic [4:0]          bit_cnt;
    logic [CMD_BITS-1:0] tx_sr;
    sample_t             rx_sr;
    logic                shift_run;
    logic                fall_en;
    logic                rise_en;

    assign tick          = enable && (timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign sample_missed = tick && busy;
    assign shift_run     = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst || !enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    spi_edge_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_edge_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (shift_run),
        .fall_en (fall_en),
        .rise_en (rise_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            spi.sclk <= 1'b1;
            spi.cs_n <= 1'b1;
            spi.mosi <= 1'b0;
            z_out    <= '0;
            z_valid  <= 1'b0;
            busy     <= 1'b0;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            z_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= CS_SETUP;
                        spi.cs_n <= 1'b0;
                        busy     <= 1'b1;
                        wait_cnt <= DIV_W'(CLK_DIV - 1);
                    end
                end
                CS_SETUP: begin
                    if (wait_cnt == '0) begin
                        // First falling half starts here with the command MSB.
                        state    <= SHIFT;
                        spi.sclk <= 1'b0;
                        spi.mosi <= CMD[CMD_BITS-1];
                        tx_sr    <= CMD << 1;
                        bit_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_en) begin
                        spi.sclk <= 1'b1;
                        if (bit_cnt >= 5'(CMD_BITS)) begin
                            rx_sr <= {rx_sr[14:0], spi.miso};
                        end
                    end else if (fall_en) begin
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            state    <= CS_HOLD;
                            wait_cnt <= DIV_W'(CLK_DIV - 1);
                        end else begin
                            spi.sclk <= 1'b0;
                            spi.mosi <= tx_sr[CMD_BITS-1];
                            tx_sr    <= tx_sr << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                CS_HOLD: begin
                    if (wait_cnt == '0) begin
                        // Low byte arrived first, so it sits in the upper half of rx_sr.
                        state    <= IDLE;
                        spi.cs_n <= 1'b1;
                        busy     <= 1'b0;
                        z_valid  <= 1'b1;
                        z_out    <= {rx_sr[7:0], rx_sr[15:8]};
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
